// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the chunked sequential adder.
// The FSM state type is exported so benches can observe progress directly.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A legal build splits WIDTH into a whole number of CHUNK-bit slices.
   function automatic bit chunk_legal(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple-carry slice built from full-adder cells.
// c_msb is the carry into the top cell, used for signed-overflow detection.
module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic c;

   always_comb begin
      c     = ci;
      s     = '0;
      c_msb = ci;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) c_msb = c;
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with valid/ready handshakes on operands and results.
module chunked_seq_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output state_t           fsm_state
);

   // Handshake rule (both sides): a transfer happens on a rising edge where
   // valid and ready are both high; a valid side holds its data until then.
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = $clog2(NCHUNK + 1);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
   localparam bit LEGAL = chunk_legal(WIDTH, CHUNK);

   state_t state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_next;
   logic             carry, accept, last;
   logic [CHUNK-1:0] chunk_s;
   logic             chunk_co, chunk_cmsb;

   assign accept    = in_valid && in_ready;
   assign last      = (cnt == LAST);
   assign in_ready  = (state == IDLE) && LEGAL;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign fsm_state = state;

   // Each new slice enters at the top; after NCHUNK slices the LSB slice sits at bit 0.
   assign sum_next = (sum >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));

   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_sh[CHUNK-1:0]),
      .b     (b_sh[CHUNK-1:0]),
      .ci    (carry),
      .s     (chunk_s),
      .co    (chunk_co),
      .c_msb (chunk_cmsb)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               // Subtraction is a + ~b + ~borrow_in, so invert B and the carry once here.
               a_sh  <= a;
               b_sh  <= b ^ {WIDTH{sub}};
               carry <= cin ^ sub;
               cnt   <= '0;
            end
            RUN: begin
               sum   <= sum_next;
               a_sh  <= a_sh >> CHUNK;
               b_sh  <= b_sh >> CHUNK;
               carry <= chunk_co;
               if (last) begin
                  cout <= chunk_co;
                  ovf  <= chunk_co ^ chunk_cmsb;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: directed steps on a CHUNK=4 build plus
// free-running random streams on CHUNK=16 and CHUNK=1 builds.
module tb_chunked_seq_adder;
   import adder_pkg::*;

   logic clk = 1'b0;
   logic rst_n, rst_s;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   go = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CHUNK=4 instance
   logic        iv4, ir4, ov4, or4, cin4, sub4, cout4, ovf4, busy4;
   logic [15:0] a4, b4, sum4;
   state_t      st4;
   // CHUNK=16 instance
   logic        iv16, ir16, ov16, or16, cin16, sub16, cout16, ovf16, busy16;
   logic [15:0] a16, b16, sum16;
   state_t      st16;
   // CHUNK=1 instance
   logic        iv1, ir1, ov1, or1, cin1, sub1, cout1, ovf1, busy1;
   logic [15:0] a1, b1, sum1;
   state_t      st1;

   chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(sum4),
      .cout(cout4), .ovf(ovf4), .busy(busy4), .fsm_state(st4));

   chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst_n(rst_s), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
      .cout(cout16), .ovf(ovf16), .busy(busy16), .fsm_state(st16));

   chunked_seq_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
      .clk(clk), .rst_n(rst_s), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(sum1),
      .cout(cout1), .ovf(ovf1), .busy(busy1), .fsm_state(st1));

   // Reference: {ovf, cout, sum} from integer arithmetic on unsigned and signed views.
   function automatic logic [17:0] ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rcin, input logic rsub);
      int ua, ub, sa, sb, r, sr;
      logic c, v;
      ua = int'(ra);
      ub = int'(rb);
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      if (!rsub) begin
         r  = ua + ub + int'(rcin);
         c  = (r > 65535);
         sr = sa + sb + int'(rcin);
      end else begin
         r  = ua - ub - int'(rcin);
         c  = (r >= 0);
         sr = sa - sb - int'(rcin);
      end
      v = (sr > 32767) || (sr < -32768);
      return {v, c, r[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op on the CHUNK=4 instance and wait for its result (not consumed).
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsub);
      logic [17:0] e;
      int lat;
      logic rdy_seen;
      e = ref_model(ta, tb_, tcin, tsub);
      for (int k = 0; k < 40 && !ir4; k++) tick();
      check({tag, "_idle"}, ir4, 1);
      a4 = ta; b4 = tb_; cin4 = tcin; sub4 = tsub; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      a4 = 16'($urandom); b4 = 16'($urandom);
      cin4 = 1'($urandom_range(0, 1)); sub4 = 1'($urandom_range(0, 1));
      check({tag, "_state_run"}, st4, RUN);
      lat = 0;
      rdy_seen = 1'b0;
      while (!ov4 && lat < 40) begin
         rdy_seen |= ir4;
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_ready_low"}, rdy_seen, 0);
      check({tag, "_sum"}, sum4, e[15:0]);
      check({tag, "_cout"}, cout4, e[16]);
      check({tag, "_ovf"}, ovf4, e[17]);
   endtask

   task automatic consume(input string tag);
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      check({tag, "_consumed"}, ov4, 0);
   endtask

   // Random stream on the CHUNK=16 instance: in_valid and out_ready held high.
   logic [17:0] exp16_q[$];
   int          acc16_q[$];
   int          n16 = 0;
   initial begin : stream16
      logic acc;
      logic [17:0] e;
      int t;
      iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
      wait (go);
      iv16 = 1'b1; or16 = 1'b1;
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
      forever begin
         @(negedge clk);
         if (ov16) begin
            if (exp16_q.size() == 0) check("s16_spurious", 1, 0);
            else begin
               e = exp16_q.pop_front();
               t = acc16_q.pop_front();
               check("s16_sum", sum16, e[15:0]);
               check("s16_flags", {ovf16, cout16}, e[17:16]);
               check("s16_latency", cyc - t - 1, 1);
               n16++;
            end
         end
         acc = iv16 && ir16;
         if (acc) begin
            exp16_q.push_back(ref_model(a16, b16, cin16, sub16));
            acc16_q.push_back(cyc);
         end
         @(posedge clk);
         #1;
         if (acc) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
         end
      end
   end

   // Random stream on the CHUNK=1 instance.
   logic [17:0] exp1_q[$];
   int          acc1_q[$];
   int          n1 = 0;
   initial begin : stream1
      logic acc;
      logic [17:0] e;
      int t;
      iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
      wait (go);
      iv1 = 1'b1; or1 = 1'b1;
      a1 = 16'($urandom); b1 = 16'($urandom);
      cin1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
      forever begin
         @(negedge clk);
         if (ov1) begin
            if (exp1_q.size() == 0) check("s1_spurious", 1, 0);
            else begin
               e = exp1_q.pop_front();
               t = acc1_q.pop_front();
               check("s1_sum", sum1, e[15:0]);
               check("s1_flags", {ovf1, cout1}, e[17:16]);
               check("s1_latency", cyc - t - 1, 16);
               n1++;
            end
         end
         acc = iv1 && ir1;
         if (acc) begin
            exp1_q.push_back(ref_model(a1, b1, cin1, sub1));
            acc1_q.push_back(cyc);
         end
         @(posedge clk);
         #1;
         if (acc) begin
            a1 = 16'($urandom); b1 = 16'($urandom);
            cin1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin : main
      logic [15:0] held;
      logic ok;
      rst_n = 1'b0; rst_s = 1'b0;
      iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
      #3;
      check("rst_in_ready", ir4, 1);
      check("rst_out_valid", ov4, 0);
      check("rst_busy", busy4, 0);
      check("rst_sum", sum4, 0);
      check("rst_flags", {cout4, ovf4}, 0);
      check("rst_state", st4, IDLE);
      check("rst16_ready", ir16, 1);
      check("rst1_ready", ir1, 1);
      tick();
      tick();
      rst_n = 1'b1; rst_s = 1'b1;
      tick();
      go = 1'b1;

      run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0);
      check("add_basic_abs", sum4, 16'h2345);
      consume("add_basic");
      run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      check("add_wrap_cout", cout4, 1);
      consume("add_wrap");
      run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      check("add_ovf_abs", {ovf4, cout4, sum4}, {2'b10, 16'h8000});
      consume("add_ovf");
      run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
      check("sub_neg_abs", {ovf4, cout4, sum4}, {2'b00, 16'hFFFE});
      consume("sub_neg");
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
      check("sub_ovf_abs", {ovf4, cout4, sum4}, {2'b11, 16'h7FFF});
      consume("sub_ovf");
      run_op("sub_borrow", 16'h0005, 16'h0002, 1'b1, 1'b1);
      check("sub_borrow_abs", sum4, 16'h0002);
      consume("sub_borrow");

      // Hold the result with out_ready low while a stray request is offered.
      run_op("hold", 16'hABCD, 16'h1357, 1'b1, 1'b0);
      held = sum4;
      iv4 = 1'b1; a4 = 16'h0F0F; b4 = 16'h0F0F;
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         ok &= ov4 && (sum4 == held) && !ir4;
      end
      check("hold_stable", ok, 1);
      iv4 = 1'b0;
      or4 = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         ok &= !ov4 && ir4;
      end
      or4 = 1'b0;
      check("hold_single_consume", ok, 1);
      run_op("after_hold", 16'h4000, 16'h4000, 1'b0, 1'b0);
      check("after_hold_abs", {ovf4, cout4, sum4}, {2'b10, 16'h8000});
      consume("after_hold");

      // Abort mid-run with an asynchronous reset.
      a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; sub4 = 1'b0; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_ready", ir4, 1);
      check("abort_valid", ov4, 0);
      check("abort_busy", busy4, 0);
      check("abort_outs", {sum4, cout4, ovf4}, 0);
      tick();
      rst_n = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         ok |= ov4;
      end
      check("abort_no_result", ok, 0);
      run_op("post_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0);
      check("post_reset_abs", sum4, 16'h0100);
      consume("post_reset");

      for (int k = 0; k < 400; k++) tick();
      check("s16_enough", n16 >= 10, 1);
      check("s1_enough", n1 >= 10, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
